// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   Raster-scan timing generator for the pixel pipeline (640x480 @ 60 Hz by
//   default, 25 MHz pixel clock). Produces the current row/column, the
//   video_on blanking qualifier, HSYNC/VSYNC, a one-clock frame-start strobe,
//   and copies of video_on/HSYNC/VSYNC delayed by SYNC_DELAY clocks so they
//   line up with pixel data leaving the pipelined icon/ROM path.
//
// Ports
//   vga_clock     in   pixel clock, all state on the rising edge
//   reset         in   asynchronous active-high reset
//   pixel_column  out  [9:0] horizontal count, 0..H_TOTAL-1
//   pixel_row     out  [9:0] vertical count, 0..V_TOTAL-1
//   video_on      out  visible-area qualifier
//   horiz_sync    out  HSYNC (active level SYNC_POL)
//   vert_sync     out  VSYNC (active level SYNC_POL)
//   frame_start   out  high for the single clock at (row, column) = (0, 0)
//   video_on_d    out  video_on delayed SYNC_DELAY clocks
//   horiz_sync_d  out  horiz_sync delayed SYNC_DELAY clocks
//   vert_sync_d   out  vert_sync delayed SYNC_DELAY clocks
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int   H_ACTIVE   = 640,
  parameter int   H_FP       = 16,
  parameter int   H_SYNC     = 96,
  parameter int   H_BP       = 48,
  parameter int   V_ACTIVE   = 480,
  parameter int   V_FP       = 10,
  parameter int   V_SYNC     = 2,
  parameter int   V_BP       = 33,
  parameter logic SYNC_POL   = 1'b0,
  parameter int   SYNC_DELAY = 3
) (
  input  logic       vga_clock,
  input  logic       reset,
  output logic [9:0] pixel_column,
  output logic [9:0] pixel_row,
  output logic       video_on,
  output logic       horiz_sync,
  output logic       vert_sync,
  output logic       frame_start,
  output logic       video_on_d,
  output logic       horiz_sync_d,
  output logic       vert_sync_d
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  // The counters are 10 bits wide; larger rasters cannot be represented.
  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_check
      $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 10-bit counter range");
    end
    if (SYNC_DELAY < 0 || SYNC_DELAY > 8) begin : g_delay_check
      $error("vga_timing_gen: SYNC_DELAY must be in 0..8");
    end
  endgenerate

  logic [9:0] col_q, col_d;
  logic [9:0] row_q, row_d;
  logic       vid_q, vid_d;
  logic       hs_q,  hs_d;
  logic       vs_q,  vs_d;
  logic       fs_q,  fs_d;

  // Decodes are taken from the next-state counts so that, once registered,
  // every output describes the same (row, column) as the counters.
  always_comb begin
    col_d = col_q + 10'd1;
    row_d = row_q;
    if (col_q == H_LAST) begin
      col_d = '0;
      row_d = (row_q == V_LAST) ? '0 : row_q + 10'd1;
    end
    vid_d = (col_d < H_VIS) && (row_d < V_VIS);
    hs_d  = (col_d >= HS_FIRST && col_d <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
    vs_d  = (row_d >= VS_FIRST && row_d <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
    fs_d  = (col_d == '0) && (row_d == '0);
  end

  // Reset parks the counters on the last pixel of the frame so the first
  // clock after release lands on (0, 0) with frame_start asserted.
  always_ff @(posedge vga_clock or posedge reset) begin
    if (reset) begin
      col_q <= H_LAST;
      row_q <= V_LAST;
      vid_q <= 1'b0;
      hs_q  <= ~SYNC_POL;
      vs_q  <= ~SYNC_POL;
      fs_q  <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      vid_q <= vid_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      fs_q  <= fs_d;
    end
  end

  assign pixel_column = col_q;
  assign pixel_row    = row_q;
  assign video_on     = vid_q;
  assign horiz_sync   = hs_q;
  assign vert_sync    = vs_q;
  assign frame_start  = fs_q;

  generate
    if (SYNC_DELAY == 0) begin : g_no_delay
      assign video_on_d   = vid_q;
      assign horiz_sync_d = hs_q;
      assign vert_sync_d  = vs_q;
    end else begin : g_delay
      // Stage i holds the undelayed signal from i+1 clocks ago.
      logic [SYNC_DELAY-1:0] vid_dly_q;
      logic [SYNC_DELAY-1:0] hs_dly_q;
      logic [SYNC_DELAY-1:0] vs_dly_q;

      always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
          vid_dly_q <= '0;
          hs_dly_q  <= {SYNC_DELAY{~SYNC_POL}};
          vs_dly_q  <= {SYNC_DELAY{~SYNC_POL}};
        end else begin
          vid_dly_q[0] <= vid_q;
          hs_dly_q[0]  <= hs_q;
          vs_dly_q[0]  <= vs_q;
          for (int i = 1; i < SYNC_DELAY; i++) begin
            vid_dly_q[i] <= vid_dly_q[i-1];
            hs_dly_q[i]  <= hs_dly_q[i-1];
            vs_dly_q[i]  <= vs_dly_q[i-1];
          end
        end
      end

      assign video_on_d   = vid_dly_q[SYNC_DELAY-1];
      assign horiz_sync_d = hs_dly_q[SYNC_DELAY-1];
      assign vert_sync_d  = vs_dly_q[SYNC_DELAY-1];
    end
  endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//   Two instances share clock and reset:
//     dut_a : default 640x480 timing, SYNC_DELAY = 3 (reset values, line
//             timing over the first 1.4 lines, delayed-output alignment)
//     dut_b : reduced raster 25x15 clocks, SYNC_DELAY = 0 (vertical timing,
//             frame wrap and frame period over several frames, mid-frame reset)
//   dut_b timing: H 16/2/4/3 -> H_TOTAL 25, HSYNC cols 18..21
//                 V  8/2/2/3 -> V_TOTAL 15, VSYNC rows 10..11, frame 375 clocks
//   Expected values are pushed into queues by the stimulus process and popped
//   and compared by a separate monitor process.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] col;
    logic [9:0] row;
    logic       vo;
    logic       hs;
    logic       vs;
    logic       fs;
    logic       vod;
    logic       hsd;
    logic       vsd;
  } exp_t;

  logic clk;
  logic rst;

  logic [9:0] pc_a, pr_a, pc_b, pr_b;
  logic vo_a, hs_a, vs_a, fs_a, vod_a, hsd_a, vsd_a;
  logic vo_b, hs_b, vs_b, fs_b, vod_b, hsd_b, vsd_b;

  vga_timing_gen #(.SYNC_DELAY(3)) dut_a (
    .vga_clock   (clk),
    .reset       (rst),
    .pixel_column(pc_a),
    .pixel_row   (pr_a),
    .video_on    (vo_a),
    .horiz_sync  (hs_a),
    .vert_sync   (vs_a),
    .frame_start (fs_a),
    .video_on_d  (vod_a),
    .horiz_sync_d(hsd_a),
    .vert_sync_d (vsd_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(3),
    .SYNC_POL(1'b0), .SYNC_DELAY(0)
  ) dut_b (
    .vga_clock   (clk),
    .reset       (rst),
    .pixel_column(pc_b),
    .pixel_row   (pr_b),
    .video_on    (vo_b),
    .horiz_sync  (hs_b),
    .vert_sync   (vs_b),
    .frame_start (fs_b),
    .video_on_d  (vod_b),
    .horiz_sync_d(hsd_b),
    .vert_sync_d (vsd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int fs_cnt   = 0;
  bit phase2   = 1'b0;

  exp_t qa[$];
  exp_t qb[$];
  exp_t aqa[$];
  exp_t aqb[$];
  int   fcq[$];
  event chk_ev;

  // Hand-derived timing constants for each instance.
  function automatic logic [2:0] dec(input int k, input bit is_a);
    int ht, vt, ha, va, h0, h1, v0, v1, c, r;
    ht = is_a ? 800 : 25;  vt = is_a ? 525 : 15;
    ha = is_a ? 640 : 16;  va = is_a ? 480 : 8;
    h0 = is_a ? 656 : 18;  h1 = is_a ? 751 : 21;
    v0 = is_a ? 490 : 10;  v1 = is_a ? 491 : 11;
    if (k < 0) return 3'b011;
    c = k % ht;
    r = (k / ht) % vt;
    return {(c < ha) && (r < va), !(c >= h0 && c <= h1), !(r >= v0 && r <= v1)};
  endfunction

  // Expected outputs k clocks after the first edge following reset release.
  function automatic exp_t model(input int k, input bit is_a);
    exp_t e;
    int ht, vt, d;
    ht = is_a ? 800 : 25;
    vt = is_a ? 525 : 15;
    d  = is_a ? 3 : 0;
    e.col = 10'(k % ht);
    e.row = 10'((k / ht) % vt);
    {e.vo, e.hs, e.vs} = dec(k, is_a);
    e.fs = ((k % (ht * vt)) == 0);
    {e.vod, e.hsd, e.vsd} = dec(k - d, is_a);
    return e;
  endfunction

  function automatic exp_t rst_exp(input bit is_a);
    exp_t e;
    e.col = is_a ? 10'd799 : 10'd24;
    e.row = is_a ? 10'd524 : 10'd14;
    e.vo = 1'b0; e.hs = 1'b1; e.vs = 1'b1; e.fs = 1'b0;
    e.vod = 1'b0; e.hsd = 1'b1; e.vsd = 1'b1;
    return e;
  endfunction

  task automatic check(input string nm, input exp_t e, input exp_t a);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got col=%0d row=%0d vo=%b hs=%b vs=%b fs=%b vod=%b hsd=%b vsd=%b; expected col=%0d row=%0d vo=%b hs=%b vs=%b fs=%b vod=%b hsd=%b vsd=%b",
               nm, a.col, a.row, a.vo, a.hs, a.vs, a.fs, a.vod, a.hsd, a.vsd,
               e.col, e.row, e.vo, e.hs, e.vs, e.fs, e.vod, e.hsd, e.vsd);
    end
  endtask

  // Monitor: per-cycle comparisons at the falling edge, plus out-of-cycle
  // checks (async reset, frame count) when the stimulus signals chk_ev.
  initial begin
    exp_t act_a, act_b;
    int   want;
    forever begin
      @(negedge clk or chk_ev);
      act_a = {pc_a, pr_a, vo_a, hs_a, vs_a, fs_a, vod_a, hsd_a, vsd_a};
      act_b = {pc_b, pr_b, vo_b, hs_b, vs_b, fs_b, vod_b, hsd_b, vsd_b};
      if (aqa.size() > 0) check("dutA_async_reset", aqa.pop_front(), act_a);
      if (aqb.size() > 0) check("dutB_async_reset", aqb.pop_front(), act_b);
      if (fcq.size() > 0) begin
        want = fcq.pop_front();
        checks++;
        if (fs_cnt != want) begin
          failures++;
          $display("FAIL dutB_frame_count: got %0d frame_start pulses, expected %0d", fs_cnt, want);
        end
      end
      if (clk == 1'b0) begin
        if (qa.size() > 0) check("dutA_cycle", qa.pop_front(), act_a);
        if (qb.size() > 0) check("dutB_cycle", qb.pop_front(), act_b);
        if (phase2 && fs_b === 1'b1) fs_cnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    // Reset held: outputs must sit at the reset values.
    repeat (3) begin
      @(posedge clk);
      qa.push_back(rst_exp(1'b1));
      qb.push_back(rst_exp(1'b0));
    end
    @(negedge clk);
    #1 rst = 1'b0;

    // First run: up to dut_b at (row 5, column 20), inside HSYNC.
    for (int k = 0; k <= 145; k++) begin
      @(posedge clk);
      qa.push_back(model(k, 1'b1));
      qb.push_back(model(k, 1'b0));
    end
    @(negedge clk);

    // Asynchronous reset between edges; checked before the next edge.
    #2 rst = 1'b1;
    #1;
    aqa.push_back(rst_exp(1'b1));
    aqb.push_back(rst_exp(1'b0));
    ->chk_ev;
    repeat (2) begin
      @(posedge clk);
      qa.push_back(rst_exp(1'b1));
      qb.push_back(rst_exp(1'b0));
    end
    @(negedge clk);
    #1 rst = 1'b0;
    phase2 = 1'b1;

    // Second run: fresh frame from (0, 0); dut_b covers three full frames.
    for (int k = 0; k < 1140; k++) begin
      @(posedge clk);
      qa.push_back(model(k, 1'b1));
      qb.push_back(model(k, 1'b0));
    end
    @(negedge clk);
    #1 phase2 = 1'b0;
    // Pulses at k = 0, 375, 750, 1125.
    fcq.push_back(4);
    ->chk_ev;
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
